// File: rtl/accum_drain_ctrl.sv
// rtl/accum_drain_ctrl.sv - burst read sequencer with credit-guarded output FIFO and valid/ready stream
// Optional clear-after-read write port enabled by `define ACCUM_DRAIN_CLEAR_EN.
module accum_drain_ctrl #(
  parameter int NUM_BANKS  = 4,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  input  logic [ADDR_WIDTH:0]             length,
  input  logic [NUM_BANKS-1:0]            lane_mask,
  output logic                            busy,
  output logic                            done,
  output logic                            rd_valid,
  input  logic                            rd_ready,
  output logic [ADDR_WIDTH-1:0]           rd_addr,
  output logic [NUM_BANKS-1:0]            rd_mask,
  output logic                            accum_en,
  input  logic                            rvalid,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] rdata,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] out_data,
`ifdef ACCUM_DRAIN_CLEAR_EN
  output logic                            out_last,
  input  logic                            clear_en,
  output logic                            wr_valid,
  input  logic                            wr_ready,
  output logic [ADDR_WIDTH-1:0]           wr_addr,
  output logic [NUM_BANKS-1:0]            wr_mask,
  output logic                            wvalid,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] wdata
`else
  output logic                            out_last
`endif
);

  localparam int DW = NUM_BANKS * DATA_WIDTH;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
  localparam logic [CW-1:0]         DEPTH = CW'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0]   ONE   = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [NUM_BANKS-1:0]  mask_q;
  logic [ADDR_WIDTH:0]   rd_left;
  logic [ADDR_WIDTH:0]   pop_left;
  logic [CW-1:0]         in_flight;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           credit_used;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DW-1:0]         mem [FIFO_DEPTH];
  logic [DW-1:0]         lane_bits;
  logic                  rd_fire, push, pop, in_drain, credit_ok, last_rd;
  logic                  wr_stall, wr_hold;

  assign in_drain    = (state == ISSUE) || (state == DRAIN);
  assign credit_used = {1'b0, in_flight} + {1'b0, fifo_count};
  assign credit_ok   = credit_used < {1'b0, DEPTH};
  // Credit check counts reads still in the wrapper pipe, so rvalid can never overrun the FIFO.
  assign rd_valid    = (state == ISSUE) && (rd_left != '0) && credit_ok && !wr_stall;
  assign rd_fire     = rd_valid && rd_ready;
  assign last_rd     = (rd_left == '0) || (rd_fire && (rd_left == ONE));
  assign rd_addr     = addr_q;
  assign rd_mask     = mask_q;

  // Stale returns (e.g. from reads issued before a reset) find no outstanding credit and are dropped.
  assign push      = rvalid && in_drain && (in_flight != '0);
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign out_last  = out_valid && (pop_left == ONE);

  always_comb begin
    lane_bits = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      lane_bits[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{mask_q[i]}};
    end
  end

  assign out_data = out_valid ? (mem[rd_ptr] & lane_bits) : '0;

`ifdef ACCUM_DRAIN_CLEAR_EN
  logic                  clr_q;
  logic                  wr_pend;
  logic [ADDR_WIDTH-1:0] wr_addr_q;

  assign wr_stall = wr_pend && !wr_ready;
  assign wr_hold  = clr_q && (wr_stall || rd_fire);
  assign accum_en = !wr_pend;
  assign wr_valid = wr_pend;
  assign wvalid   = wr_pend;
  assign wr_addr  = wr_addr_q;
  assign wr_mask  = wr_pend ? mask_q : '0;
  assign wdata    = '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clr_q     <= 1'b0;
      wr_pend   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      if ((state == IDLE) && start) clr_q <= clear_en;
      if (rd_fire && clr_q) begin
        wr_pend   <= 1'b1;
        wr_addr_q <= addr_q;
      end else if (wr_ready) begin
        wr_pend <= 1'b0;
      end
    end
  end
`else
  assign wr_stall = 1'b0;
  assign wr_hold  = 1'b0;
  assign accum_en = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (length == '0) ? DONE : ISSUE;
      end
      ISSUE: if (last_rd && !wr_hold) state_nxt = DRAIN;
      // pop_left can already be zero when a stalled clear write kept us in ISSUE past the last pop.
      DRAIN: if ((pop_left == '0) || (pop && (pop_left == ONE))) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      addr_q     <= '0;
      mask_q     <= '0;
      rd_left    <= '0;
      pop_left   <= '0;
      in_flight  <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && start) begin
        addr_q   <= base_addr;
        mask_q   <= lane_mask;
        rd_left  <= length;
        pop_left <= length;
      end else if (rd_fire) begin
        addr_q  <= addr_q + ADDR_WIDTH'(1);
        rd_left <= rd_left - ONE;
      end
      if (pop) begin
        pop_left <= pop_left - ONE;
        rd_ptr   <= rd_ptr + PW'(1);
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      in_flight  <= in_flight + CW'(rd_fire) - CW'(push);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rdata;
  end

  overflow_chk: assert property (@(posedge clk) disable iff (!rstn)
    !(push && !pop && (fifo_count == DEPTH)));

endmodule

// File: tb/tb_accum_drain_ctrl.sv
// tb/tb_accum_drain_ctrl.sv - self-checking bench for accum_drain_ctrl
module tb_accum_drain_ctrl;
  localparam int NB = 4, AW = 9, DW = 64, FD = 4, W = NB * DW;

  logic          clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic [NB-1:0] lane_mask = '0;
  logic          busy, done, rd_valid, accum_en, out_valid, out_last, rvalid;
  logic          rd_ready = 1'b1, out_ready = 1'b1, spur = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [NB-1:0] rd_mask;
  logic [W-1:0]  rdata, out_data;

  accum_drain_ctrl dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .length(length),
    .lane_mask(lane_mask), .busy(busy), .done(done), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_addr(rd_addr), .rd_mask(rd_mask), .accum_en(accum_en), .rvalid(rvalid), .rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] word_of(input logic [AW-1:0] a);
    logic [W-1:0] w;
    for (int i = 0; i < NB; i++) w[i*DW +: DW] = {16'hA5C0 + 16'(i), 16'(a), 32'(a) * 32'h9E3779B1};
    return w;
  endfunction

  function automatic logic [W-1:0] mask_word(input logic [W-1:0] w, input logic [NB-1:0] m);
    logic [W-1:0] r;
    r = w;
    for (int i = 0; i < NB; i++) if (!m[i]) r[i*DW +: DW] = '0;
    return r;
  endfunction

  // Wrapper model: fixed two-cycle read pipe, no reset so pre-reset reads still return.
  logic          p1_v = 1'b0, p2_v = 1'b0;
  logic [AW-1:0] p1_a = '0, p2_a = '0;
  always @(posedge clk) begin
    p1_v <= rd_valid && rd_ready;
    p1_a <= rd_addr;
    p2_v <= p1_v;
    p2_a <= p1_a;
  end
  assign rvalid = p2_v | spur;
  assign rdata  = word_of(p2_a);

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  logic [AW-1:0] exp_addr[$];
  logic [W-1:0]  exp_data[$];
  logic [NB-1:0] exp_mask;
  logic [AW-1:0] first_addr, last_addr, stall_addr;
  logic [W-1:0]  held_data;
  int  rd_idx, pop_idx, done_cnt, cyc = 0;
  int  first_rd_cyc, last_rd_cyc, first_ov_cyc, last_pop_cyc, done_cyc;
  int  hold_left = 0;
  bit  active = 1'b0, rnd_mode = 1'b0, hold_prev = 1'b0, rd_stall_prev = 1'b0;

  initial forever begin
    @(posedge clk); #1;
    if (hold_left > 0) begin
      out_ready = 1'b0;
      hold_left--;
    end else begin
      out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    rd_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial forever begin
    @(negedge clk);
    cyc++;
    if (active && rstn) begin
      if (rd_stall_prev) begin
        chk("rd_hold_valid", W'(rd_valid), W'(1));
        chk("rd_hold_addr", W'(rd_addr), W'(stall_addr));
      end
      rd_stall_prev = rd_valid && !rd_ready;
      stall_addr = rd_addr;
      if (rd_valid && rd_ready) begin
        if (rd_idx < exp_addr.size()) begin
          chk("rd_addr", W'(rd_addr), W'(exp_addr[rd_idx]));
          chk("rd_mask", W'(rd_mask), W'(exp_mask));
        end else begin
          chk("rd_extra", W'(rd_idx), W'(exp_addr.size()));
        end
        if (rd_idx == 0) begin
          first_rd_cyc = cyc;
          first_addr = rd_addr;
        end
        last_rd_cyc = cyc;
        last_addr = rd_addr;
        rd_idx++;
      end
      chk("credit", W'(rd_idx - pop_idx <= FD), W'(1));
      if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (hold_prev) begin
        chk("out_hold_valid", W'(out_valid), W'(1));
        chk("out_hold_data", out_data, held_data);
      end
      hold_prev = out_valid && !out_ready;
      held_data = out_data;
      if (out_valid && out_ready) begin
        if (pop_idx < exp_data.size()) begin
          chk("out_data", out_data, exp_data[pop_idx]);
          chk("out_last", W'(out_last), W'(pop_idx == exp_data.size() - 1));
        end else begin
          chk("out_extra", W'(pop_idx), W'(exp_data.size()));
        end
        pop_idx++;
        last_pop_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      hold_prev = 1'b0;
      rd_stall_prev = 1'b0;
    end
  end

  task automatic setup_exp(input logic [AW-1:0] b, input logic [AW:0] n, input logic [NB-1:0] m);
    logic [AW-1:0] a;
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < int'(n); i++) begin
      a = b + AW'(i);
      exp_addr.push_back(a);
      exp_data.push_back(mask_word(word_of(a), m));
    end
    exp_mask = m;
    rd_idx = 0; pop_idx = 0; done_cnt = 0;
    first_rd_cyc = -1; last_rd_cyc = -1; first_ov_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
  endtask

  task automatic kick(input logic [AW-1:0] b, input logic [AW:0] n, input logic [NB-1:0] m,
                      input bit rnd, input int hold);
    setup_exp(b, n, m);
    @(negedge clk);
    hold_left = hold;
    rnd_mode = rnd;
    active = 1'b1;
    @(posedge clk); #1;
    base_addr = b; length = n; lane_mask = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = AW'($urandom); length = (AW+1)'($urandom); lane_mask = NB'($urandom);
  endtask

  task automatic run_drain(input logic [AW-1:0] b, input logic [AW:0] n, input logic [NB-1:0] m,
                           input bit rnd, input int hold, input bit timing);
    kick(b, n, m, rnd, hold);
    if (hold > 0) begin
      repeat (18) @(negedge clk);
      chk("hold_reads", W'(rd_idx), W'(FD));
    end
    for (int t = 0; t < 3000 && done_cnt == 0; t++) @(negedge clk);
    if (done_cnt == 0) begin
      errors++; checks++;
      $display("FAIL drain_timeout got no done expected done within 3000 cycles");
    end
    repeat (2) @(negedge clk);
    chk("idle_after", W'(busy), W'(0));
    chk("done_count", W'(done_cnt), W'(1));
    chk("read_count", W'(rd_idx), W'(n));
    chk("word_count", W'(pop_idx), W'(n));
    chk("done_after_last", W'(done_cyc), W'(last_pop_cyc + 1));
    if (timing) begin
      chk("back_to_back", W'(last_rd_cyc - first_rd_cyc), W'(int'(n) - 1));
      chk("first_latency", W'(first_ov_cyc - first_rd_cyc), W'(3));
    end
    active = 1'b0;
    rnd_mode = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic [NB-1:0] mask;
    int            hold;
    bit            timing;
    logic [AW-1:0] exp_first;
    logic [AW-1:0] exp_last;
  } vec_t;
  vec_t vt[4];

  initial begin
    vt[0] = '{9'h010, 10'd8, 4'b1111, 0,  1'b1, 9'h010, 9'h017};
    vt[1] = '{9'h1FE, 10'd4, 4'b1111, 0,  1'b1, 9'h1FE, 9'h001};
    vt[2] = '{9'h020, 10'd8, 4'b1111, 20, 1'b0, 9'h020, 9'h027};
    vt[3] = '{9'h100, 10'd5, 4'b0101, 0,  1'b1, 9'h100, 9'h104};

    repeat (2) @(negedge clk);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_rd_valid", W'(rd_valid), W'(0));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_last", W'(out_last), W'(0));
    chk("rst_rd_addr", W'(rd_addr), W'(0));
    chk("rst_rd_mask", W'(rd_mask), W'(0));
    chk("rst_out_data", out_data, W'(0));
    chk("rst_accum_en", W'(accum_en), W'(1));
    @(posedge clk); #1;
    rstn = 1'b1;

    for (int k = 0; k < 4; k++) begin
      run_drain(vt[k].base, vt[k].len, vt[k].mask, 1'b0, vt[k].hold, vt[k].timing);
      chk("first_addr", W'(first_addr), W'(vt[k].exp_first));
      chk("last_addr", W'(last_addr), W'(vt[k].exp_last));
    end

    @(posedge clk); #1;
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    @(negedge clk);
    chk("spur_ignored", W'(out_valid), W'(0));

    setup_exp('0, '0, '0);
    @(negedge clk);
    active = 1'b1;
    @(posedge clk); #1;
    base_addr = 9'h055; length = '0; lane_mask = 4'hF; start = 1'b1;
    @(negedge clk);
    chk("len0_pre_done", W'(done), W'(0));
    @(posedge clk); #1;
    length = 10'd5;
    @(negedge clk);
    chk("len0_done", W'(done), W'(1));
    chk("len0_busy", W'(busy), W'(1));
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("len0_done_end", W'(done), W'(0));
    chk("len0_ignore_start", W'(busy), W'(0));
    repeat (8) @(negedge clk);
    chk("len0_reads", W'(rd_idx), W'(0));
    chk("len0_done_cnt", W'(done_cnt), W'(1));
    active = 1'b0;

    kick(9'h040, 10'd8, 4'hF, 1'b0, 0);
    for (int t = 0; t < 200 && pop_idx < 3; t++) @(negedge clk);
    chk("abort_point", W'(pop_idx >= 3), W'(1));
    @(posedge clk); #1;
    active = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_done", W'(done), W'(0));
    chk("abort_rd_valid", W'(rd_valid), W'(0));
    chk("abort_out_valid", W'(out_valid), W'(0));
    chk("abort_out_last", W'(out_last), W'(0));
    chk("abort_rd_addr", W'(rd_addr), W'(0));
    chk("abort_out_data", out_data, W'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      chk("abort_no_done", W'(done), W'(0));
      chk("abort_stale_drop", W'(out_valid), W'(0));
    end
    run_drain(9'h0F0, 10'd6, 4'b1010, 1'b0, 0, 1'b1);
    chk("post_abort_first", W'(first_addr), W'(9'h0F0));

    for (int r = 0; r < 8; r++) begin
      run_drain(AW'($urandom), (AW+1)'($urandom_range(1, 12)), NB'($urandom_range(1, 15)), 1'b1, 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
